pwm_phase_seq: RTL and testbench



---
 rtl/pwm_phase_seq_if.sv | 14 +
 rtl/pwm_phase_seq.sv | 187 ++++++++++++++++++
 tb/tb_pwm_phase_seq.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_phase_seq_if.sv
// Command channel into pwm_phase_seq: one phase-move request per valid/ready transfer.
interface pwm_phase_seq_if #(
   parameter int PWM_CNT_WIDTH = 24,
   parameter int CH_W          = 6
);
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [CH_W-1:0]          cmd_ch;
   logic [PWM_CNT_WIDTH-1:0] cmd_target;
   logic [PWM_CNT_WIDTH-1:0] cmd_step;

   modport master (output cmd_valid, cmd_ch, cmd_target, cmd_step, input cmd_ready);
   modport slave  (input cmd_valid, cmd_ch, cmd_target, cmd_step, output cmd_ready);
endinterface

// File: rtl/pwm_phase_seq.sv
// Phase sequencer: ramps one PWM channel's phase toward a commanded target, one step per period.
// PWM_PHASE_SEQ_FIFO_EN selects a 4-entry command FIFO instead of a single holding register.
module pwm_phase_seq #(
   parameter int PWM_CNT       = 64,
   parameter int PWM_CNT_WIDTH = 24,
   parameter int CH_W          = $clog2(PWM_CNT)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   pwm_phase_seq_if.slave                   cmd,
   input  logic                             abort_i,
   input  logic                             period_tick_i,
   input  logic [PWM_CNT_WIDTH-1:0]         pwm_period_i,
   input  logic [PWM_CNT*PWM_CNT_WIDTH-1:0] pwm_man_phase_i,
   output logic [PWM_CNT-1:0]               pwm_ctrl_o,
   output logic [PWM_CNT*PWM_CNT_WIDTH-1:0] pwm_auto_phase_o,
   output logic [PWM_CNT-1:0]               pwm_auto_end_o,
   output logic                             busy_o
);
   localparam int W = PWM_CNT_WIDTH;

   typedef enum logic [2:0] {IDLE, LOAD, WAIT, STEP, DONE} state_t;

   typedef struct packed {
      logic [CH_W-1:0] ch;
      logic [W-1:0]    target;
      logic [W-1:0]    step;
   } cmd_t;

   state_t state;
   logic   push;
   logic   pop;
   logic   pending;
   cmd_t   head;
   cmd_t   in_cmd;

   assign in_cmd = '{ch: cmd.cmd_ch, target: cmd.cmd_target, step: cmd.cmd_step};
   assign push   = cmd.cmd_valid && cmd.cmd_ready;
   assign pop    = (state == IDLE) && pending && !abort_i;
   assign busy_o = (state != IDLE) || pending;

`ifdef PWM_PHASE_SEQ_FIFO_EN
   cmd_t       fifo_mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;

   assign pending       = (count != '0);
   assign head          = fifo_mem[rd_ptr];
   assign cmd.cmd_ready = (count != 3'd4) && !abort_i;

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr] <= in_cmd;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (abort_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         count <= count + {2'b00, push} - {2'b00, pop};
      end
   end
`else
   cmd_t hold;
   logic hold_valid;

   assign pending       = hold_valid;
   assign head          = hold;
   assign cmd.cmd_ready = (state == IDLE) && !hold_valid && !abort_i;

   // push needs an empty holder and pop a full one, so they never coincide
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold       <= '0;
         hold_valid <= 1'b0;
      end else if (abort_i) begin
         hold_valid <= 1'b0;
      end else if (push) begin
         hold       <= in_cmd;
         hold_valid <= 1'b1;
      end else if (pop) begin
         hold_valid <= 1'b0;
      end
   end
`endif

   logic [CH_W-1:0] ch_r;
   logic [W-1:0]    tgt_raw_r;
   logic [W-1:0]    step_r;
   logic [W-1:0]    cur;
   logic [W-1:0]    tgt;
   logic [W-1:0]    man_phase;
   logic [W-1:0]    load_tgt;
   logic [W-1:0]    diff;
   logic [W-1:0]    delta;
   logic [W-1:0]    step_nxt;
   logic            up;

   // step size is clipped to the remaining distance, so the ramp never overshoots or wraps
   always_comb begin
      man_phase = pwm_man_phase_i[int'(ch_r)*W +: W];
      if (pwm_period_i == '0)
         load_tgt = '0;
      else if (tgt_raw_r > pwm_period_i - 1'b1)
         load_tgt = pwm_period_i - 1'b1;
      else
         load_tgt = tgt_raw_r;
      up       = tgt > cur;
      diff     = up ? (tgt - cur) : (cur - tgt);
      delta    = ((step_r == '0) || (step_r > diff)) ? diff : step_r;
      step_nxt = up ? (cur + delta) : (cur - delta);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state            <= IDLE;
         ch_r             <= '0;
         tgt_raw_r        <= '0;
         step_r           <= '0;
         cur              <= '0;
         tgt              <= '0;
         pwm_ctrl_o       <= '0;
         pwm_auto_phase_o <= '0;
         pwm_auto_end_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  ch_r      <= head.ch;
                  tgt_raw_r <= head.target;
                  step_r    <= head.step;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               cur                                <= man_phase;
               tgt                                <= load_tgt;
               pwm_ctrl_o[ch_r]                   <= 1'b1;
               pwm_auto_phase_o[int'(ch_r)*W +: W] <= man_phase;
               if (abort_i || (man_phase == load_tgt)) begin
                  pwm_auto_end_o[ch_r] <= 1'b1;
                  state                <= DONE;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (abort_i) begin
                  pwm_auto_end_o[ch_r] <= 1'b1;
                  state                <= DONE;
               end else if (period_tick_i) begin
                  state <= STEP;
               end
            end
            STEP: begin
               if (abort_i) begin
                  pwm_auto_end_o[ch_r] <= 1'b1;
                  state                <= DONE;
               end else begin
                  cur                                 <= step_nxt;
                  pwm_auto_phase_o[int'(ch_r)*W +: W] <= step_nxt;
                  if (step_nxt == tgt) begin
                     pwm_auto_end_o[ch_r] <= 1'b1;
                     state                <= DONE;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            DONE: begin
               pwm_auto_end_o <= '0;
               pwm_ctrl_o     <= '0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pwm_phase_seq.sv
// Bench for pwm_phase_seq: vector table, hand-written corner sequences and random ramps
// compared against a phase-list model of the ramp rules.
module tb_pwm_phase_seq;
   localparam int N  = 64;
   localparam int W  = 24;
   localparam int CW = 6;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         abort = 1'b0;
   logic         tick = 1'b0;
   logic [W-1:0] period = '0;
   logic [W-1:0] man_arr [N];
   logic [N*W-1:0] man_flat;
   logic [N-1:0]   ctrl;
   logic [N-1:0]   aend;
   logic [N*W-1:0] aphase;
   logic           busy;

   pwm_phase_seq_if #(.PWM_CNT_WIDTH(W), .CH_W(CW)) cmd_if ();

   pwm_phase_seq #(.PWM_CNT(N), .PWM_CNT_WIDTH(W), .CH_W(CW)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .cmd              (cmd_if),
      .abort_i          (abort),
      .period_tick_i    (tick),
      .pwm_period_i     (period),
      .pwm_man_phase_i  (man_flat),
      .pwm_ctrl_o       (ctrl),
      .pwm_auto_phase_o (aphase),
      .pwm_auto_end_o   (aend),
      .busy_o           (busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      man_flat = '0;
      for (int i = 0; i < N; i++) man_flat[i*W +: W] = man_arr[i];
   end

   typedef struct {
      int ch;
      int man;
      int target;
      int step;
      int period;
      int exp_steps;
      int exp_final;
   } vec_t;

   int total = 0;
   int bad = 0;
   int exp_q[$];
   int obs_q[$];
   int end_cnt, rise_cyc, end_cyc, fall_cyc, end_phase, end_ctrl_ok;
   int lat_bad, timed_out, busy_after_abort;
   int onehot_bad = 0;

   function automatic int phase_of(input int ch);
      return int'(aphase[ch*W +: W]);
   endfunction

   // expected list of visible phases: start value, then one entry per consumed period
   function automatic void model(input int man, input int tin, input int stp, input int per);
      int t, p;
      t = (per == 0) ? 0 : ((tin < per) ? tin : per - 1);
      exp_q.delete();
      p = man;
      exp_q.push_back(p);
      while (p != t) begin
         if (stp == 0)   p = t;
         else if (t > p) p = (t - p > stp) ? p + stp : t;
         else            p = (p - t > stp) ? p - stp : t;
         exp_q.push_back(p);
      end
   endfunction

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_seq(input string name);
      int idx = -1;
      int n;
      total++;
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         if (idx < 0 && obs_q[i] != exp_q[i]) idx = i;
      if (idx < 0 && obs_q.size() != exp_q.size()) idx = n;
      if (idx >= 0) begin
         bad++;
         $display("FAIL %s: phase #%0d got %0d expected %0d (lengths %0d/%0d)", name, idx,
                  (idx < obs_q.size()) ? obs_q[idx] : -1,
                  (idx < exp_q.size()) ? exp_q[idx] : -1, obs_q.size(), exp_q.size());
      end
   endtask

   // called at a negedge, returns at the negedge after the transfer edge
   task automatic send_cmd(input int ch, input int tgt, input int stp, output int ok);
      int waitc = 0;
      ok = 1;
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_ch     = CW'(ch);
      cmd_if.cmd_target = W'(tgt);
      cmd_if.cmd_step   = W'(stp);
      while (!cmd_if.cmd_ready) begin
         @(negedge clk);
         waitc++;
         if (waitc > 200) begin
            ok = 0;
            break;
         end
      end
      if (ok == 1) @(posedge clk);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic watch(input int ch, input int tper, input int abort_after);
      int  last_tick = -100;
      bit  prev_ctrl, aborted;
      obs_q.delete();
      end_cnt = 0; rise_cyc = -1; end_cyc = -1; fall_cyc = -1; end_phase = -1;
      end_ctrl_ok = 0; lat_bad = 0; timed_out = 1; busy_after_abort = -1;
      prev_ctrl = ctrl[ch];
      aborted = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if ($countones(ctrl) > 1 || $countones(aend) > 1) onehot_bad++;
         if (ctrl[ch]) begin
            if (!prev_ctrl) rise_cyc = cyc;
            if (obs_q.size() == 0) obs_q.push_back(phase_of(ch));
            else if (phase_of(ch) != obs_q[$]) begin
               obs_q.push_back(phase_of(ch));
               if (cyc - last_tick != 2) lat_bad++;
            end
         end
         if (aend[ch]) begin
            end_cnt++;
            end_cyc     = cyc;
            end_phase   = phase_of(ch);
            end_ctrl_ok = int'(ctrl[ch]);
         end
         if (prev_ctrl && !ctrl[ch]) begin
            fall_cyc = cyc;
            if (aborted) busy_after_abort = int'(busy);
            timed_out = 0;
            break;
         end
         prev_ctrl = ctrl[ch];
         abort = 1'b0;
         if (abort_after >= 0 && !aborted && obs_q.size() == abort_after + 1) begin
            abort   = 1'b1;
            aborted = 1'b1;
         end
         tick = ((cyc % tper) == tper - 1) && !abort;
         if (tick) last_tick = cyc;
         @(negedge clk);
      end
      abort = 1'b0;
      tick  = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string name, input int tper);
      int ok;
      man_arr[v.ch] = W'(v.man);
      period        = W'(v.period);
      model(v.man, v.target, v.step, v.period);
      send_cmd(v.ch, v.target, v.step, ok);
      check({name, "_accept"}, ok, 1);
      watch(v.ch, tper, -1);
      check({name, "_timeout"}, timed_out, 0);
      check_seq({name, "_seq"});
      check({name, "_steps"}, obs_q.size() - 1, v.exp_steps);
      check({name, "_end_cnt"}, end_cnt, 1);
      check({name, "_end_phase"}, end_phase, v.exp_final);
      check({name, "_end_ctrl"}, end_ctrl_ok, 1);
      check({name, "_ctrl_fall"}, fall_cyc - end_cyc, 1);
      check({name, "_latency"}, lat_bad, 0);
      check({name, "_hold"}, phase_of(v.ch), v.exp_final);
      if (v.exp_steps == 0) check({name, "_direct_done"}, end_cyc - rise_cyc, 0);
   endtask

   vec_t vecs [7];

   initial begin
      int ok, accepted, limit, idle_bad;
      vec_t v;
      vecs[0] = '{5,  100, 130,  10,  1000, 3, 130};
      vecs[1] = '{7,  50,  5,    20,  1000, 3, 5};
      vecs[2] = '{0,  990, 2000, 4,   1000, 3, 999};
      vecs[3] = '{63, 77,  77,   5,   1000, 0, 77};
      vecs[4] = '{12, 10,  500,  0,   1000, 1, 500};
      vecs[5] = '{3,  0,   40,   5,   0,    0, 0};
      vecs[6] = '{33, 800, 100,  250, 900,  3, 100};

      for (int i = 0; i < N; i++) man_arr[i] = W'($urandom_range(0, 999));
      cmd_if.cmd_valid  = 1'b0;
      cmd_if.cmd_ch     = '0;
      cmd_if.cmd_target = '0;
      cmd_if.cmd_step   = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ctrl",  int'(ctrl != '0), 0);
      check("rst_phase", int'(aphase != '0), 0);
      check("rst_end",   int'(aend != '0), 0);
      check("rst_busy",  int'(busy), 0);
      check("rst_ready", int'(cmd_if.cmd_ready), 1);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 20);

      // abort after the second step of a 10-step ramp
      @(negedge clk);
      man_arr[9] = W'(200);
      period     = W'(1000);
      model(200, 300, 10, 1000);
      while (exp_q.size() > 3) void'(exp_q.pop_back());
      send_cmd(9, 300, 10, ok);
      check("abort_accept", ok, 1);
`ifdef PWM_PHASE_SEQ_FIFO_EN
      send_cmd(20, 900, 5, ok);
      check("abort_q1", ok, 1);
      send_cmd(21, 900, 5, ok);
      check("abort_q2", ok, 1);
`endif
      watch(9, 20, 2);
      check("abort_timeout", timed_out, 0);
      check_seq("abort_seq");
      check("abort_end_cnt", end_cnt, 1);
      check("abort_end_phase", end_phase, 220);
      check("abort_busy", busy_after_abort, 0);
      idle_bad = 0;
      for (int c = 0; c < 60; c++) begin
         tick = (c % 5) == 4;
         @(negedge clk);
         if (ctrl != '0 || busy) idle_bad++;
      end
      tick = 1'b0;
      check("abort_flushed", idle_bad, 0);

      // six back-to-back commands with no period ticks
      man_arr[1] = '0;
`ifdef PWM_PHASE_SEQ_FIFO_EN
      limit = 5;
`else
      limit = 1;
`endif
      accepted = 0;
      for (int c = 0; c < 40; c++) begin
         cmd_if.cmd_valid  = accepted < 6;
         cmd_if.cmd_ch     = (accepted == 0) ? CW'(1) : CW'(40 + accepted);
         cmd_if.cmd_target = W'(100);
         cmd_if.cmd_step   = W'(10);
         if (cmd_if.cmd_valid && cmd_if.cmd_ready) accepted++;
         @(negedge clk);
      end
      check("bp_accepted", accepted, limit);
      check("bp_ready_low", int'(cmd_if.cmd_ready), 0);
      check("bp_ramp_active", int'(ctrl[1]), 1);
      cmd_if.cmd_valid = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      for (int c = 0; c < 20 && busy; c++) @(negedge clk);
      check("bp_idle", int'(busy), 0);
      check("bp_ctrl_clear", int'(ctrl != '0), 0);

      // asynchronous reset while waiting for a period tick
      man_arr[4] = W'(10);
      period     = W'(1000);
      send_cmd(4, 100, 10, ok);
      check("rstw_accept", ok, 1);
      for (int c = 0; c < 40 && phase_of(4) != 20; c++) begin
         tick = (c == 5);
         @(negedge clk);
      end
      tick = 1'b0;
      check("rstw_stepped", phase_of(4), 20);
      rst = 1'b1;
      #1;
      check("rstw_ctrl",  int'(ctrl != '0), 0);
      check("rstw_phase", int'(aphase != '0), 0);
      check("rstw_busy",  int'(busy), 0);
      idle_bad = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (aend != '0) idle_bad++;
      end
      rst = 1'b0;
      @(negedge clk);
      if (aend != '0) idle_bad++;
      check("rstw_no_end", idle_bad, 0);
      v = '{4, 10, 100, 10, 1000, 9, 100};
      run_vec(v, "rstw_rerun", 3);

      // random ramps against the model
      for (int r = 0; r < 25; r++) begin
         int ch, man, tg, stp, per, tper;
         ch   = $urandom_range(0, N - 1);
         man  = $urandom_range(0, 700);
         tg   = $urandom_range(0, 900);
         per  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(300, 800);
         stp  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(40, 300);
         tper = $urandom_range(3, 6);
         man_arr[ch] = W'(man);
         period      = W'(per);
         model(man, tg, stp, per);
         send_cmd(ch, tg, stp, ok);
         check("rnd_accept", ok, 1);
         watch(ch, tper, -1);
         check("rnd_timeout", timed_out, 0);
         check_seq($sformatf("rnd%0d_seq", r));
         check("rnd_end_cnt", end_cnt, 1);
         check("rnd_end_phase", end_phase, exp_q[$]);
         check("rnd_latency", lat_bad, 0);
         man_arr[ch] = W'($urandom_range(0, 999));
      end

      check("onehot", onehot_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
